adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
- Digital ADSR (attack/decay/sustain/release) envelope generator for the synth voice path.
- A level-sensitive gate `trig` drives a five-state FSM.
- The FSM ramps an 8-bit unsigned envelope by programmable signed per-clock increments toward 255, then down to the sustain level, then to 0.
- `envelope` feeds the downstream amplitude multiplier.

Parameters:
- None. All ADSR settings are run-time ports. One envelope step is taken per clock.

Ports:
- clk       in   1  system clock; all logic on the rising edge
- rst       in   1  synchronous reset, active-high
- trig      in   1  gate/note-on; level sensitive, high = key held
- ai        in   8  attack increment, signed two's complement (e.g. +5)
- di        in   8  decay increment, signed two's complement (e.g. -10)
- s         in   8  sustain level, unsigned 0..255
- ri        in   8  release increment, signed two's complement (e.g. -1)
- envelope  out  8  current envelope level, unsigned, registered

Behaviour:
- One clock; rst is synchronous and active-high.
- Reset: state=IDLE, envelope=0. rst overrides all other inputs, including mid-ramp.
- Arithmetic:
  - sum = zero-extend(envelope) + sign-extend(increment), computed in at least 10-bit signed.
  - Results are clamped to 0..255. No wrap-around is permitted.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Inputs are sampled every rising edge.
- IDLE:
  - trig=1 -> ATTACK, envelope unchanged this cycle.
  - Otherwise stay; envelope holds (0 after a completed release).
- ATTACK:
  - trig=0 -> RELEASE, envelope held this cycle.
  - Else if ai<=0 -> envelope=255, go DECAY (instant attack).
  - Else sum=envelope+ai. If sum>=255: envelope=255, go DECAY. Else envelope=sum.
- DECAY:
  - trig=0 -> RELEASE, envelope held.
  - Else if di>=0 -> envelope=s, go SUSTAIN.
  - Else sum=envelope+di. If sum<=s: envelope=s, go SUSTAIN. Else envelope=sum.
- SUSTAIN:
  - trig=0 -> RELEASE, envelope held.
  - Else envelope=s every cycle, so it tracks live changes to s. Stay.
- RELEASE:
  - trig=1 -> ATTACK, envelope held. Retrigger starts from the current level, not from 0.
  - Else if ri>=0 -> envelope=0, go IDLE.
  - Else sum=envelope+ri. If sum<=0: envelope=0, go IDLE. Else envelope=sum.
- Priority: trig checks precede ramp logic in every state.
- The level that completes a phase (255, s, 0) is written in the same cycle as the state change.
- Increments and s may change at any time; each cycle uses the value present on that edge.
- Edge case: s=255 means DECAY jumps to SUSTAIN on its first cycle with envelope=255.
- The bench is level-based only; no trig edge detection is required.

Test Plan:
1. Reset: rst=1 for 5 cycles with trig=1 -> envelope=0 throughout. The first ATTACK-state edge comes one cycle after rst falls; envelope remains 0 that cycle.
2. Full ADSR with ai=5, di=-10, s=65, ri=-1; trig high one cycle after reset and held ~400 cycles:
   - Envelope sequence after ATTACK entry: 5,10,...,250,255 (255 on the 51st step).
   - Then 245,235,...,75,65 (19 steps) and holds 65.
   - After trig drops: one hold cycle at 65, then 64,...,1,0 over 65 cycles, then IDLE with envelope stays 0.
3. Saturation: ai=100 from 0 -> 100,200,255 (clamped, not 300/wrapped), then DECAY. ri=-100 from s=65 -> 0 in one step, IDLE.
4. Early release: drop trig mid-attack at envelope=50 -> one hold cycle at 50, then release ramp 49,48,... to 0.
5. Retrigger in RELEASE at envelope=30 with trig=1 -> one hold cycle at 30, then 35,40,... with ai=5.
6. Degenerate increments and live sustain:
   - ai=0 -> envelope jumps to 255 on the first ATTACK cycle.
   - di=0 -> envelope jumps to s.
   - ri=0 -> envelope jumps to 0.
   - Changing s from 65 to 100 during SUSTAIN -> envelope=100 on the next edge.

Source files
------------

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: a level-sensitive gate walks attack/decay/sustain/release,
// ramping an 8-bit level by signed per-clock increments with clamping to 0..255.
//
// state   | meaning
// IDLE    | no note; envelope holds (0 after a finished release)
// ATTACK  | ramp up by ai toward 255
// DECAY   | ramp down by di toward sustain level s
// SUSTAIN | envelope follows s while the gate is held
// RELEASE | ramp down by ri toward 0
module adsr_envelope (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [7:0] ai,
  input  logic [7:0] di,
  input  logic [7:0] s,
  input  logic [7:0] ri,
  output logic [7:0] envelope
);

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] env_nxt;

  // 10-bit signed sums are wide enough for 255 + 127 and 0 - 128 without wrapping
  logic signed [9:0] sum_a, sum_d, sum_r, s_ext;

  assign sum_a = $signed({2'b00, envelope}) + $signed({{2{ai[7]}}, ai});
  assign sum_d = $signed({2'b00, envelope}) + $signed({{2{di[7]}}, di});
  assign sum_r = $signed({2'b00, envelope}) + $signed({{2{ri[7]}}, ri});
  assign s_ext = $signed({2'b00, s});

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      envelope <= 8'd0;
    end else begin
      state    <= state_nxt;
      envelope <= env_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    env_nxt   = envelope;
    case (state)
      IDLE: begin
        if (trig) state_nxt = ATTACK;
      end
      ATTACK: begin
        if (!trig) begin
          state_nxt = RELEASE;
        end else if (ai[7] || (ai == 8'd0)) begin
          env_nxt   = 8'd255;
          state_nxt = DECAY;
        end else if (sum_a >= 10'sd255) begin
          env_nxt   = 8'd255;
          state_nxt = DECAY;
        end else begin
          env_nxt = sum_a[7:0];
        end
      end
      DECAY: begin
        if (!trig) begin
          state_nxt = RELEASE;
        end else if (!di[7]) begin
          env_nxt   = s;
          state_nxt = SUSTAIN;
        end else if (sum_d <= s_ext) begin
          env_nxt   = s;
          state_nxt = SUSTAIN;
        end else begin
          env_nxt = sum_d[7:0];
        end
      end
      SUSTAIN: begin
        if (!trig) state_nxt = RELEASE;
        else       env_nxt   = s;
      end
      RELEASE: begin
        if (trig) begin
          state_nxt = ATTACK;
        end else if (!ri[7]) begin
          env_nxt   = 8'd0;
          state_nxt = IDLE;
        end else if (sum_r <= 10'sd0) begin
          env_nxt   = 8'd0;
          state_nxt = IDLE;
        end else begin
          env_nxt = sum_r[7:0];
        end
      end
      default: begin
        state_nxt = IDLE;
        env_nxt   = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Testbench for adsr_envelope: directed ADSR scenarios plus random stimulus,
// checked against a phase-level reference model written with plain integer arithmetic.
module tb_adsr_envelope;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [7:0] ai = 8'd0;
  logic [7:0] di = 8'd0;
  logic [7:0] s = 8'd0;
  logic [7:0] ri = 8'd0;
  logic [7:0] envelope;

  int vectors = 0;
  int errs = 0;

  // reference model: phase names as strings, level as an unbounded int
  string m_phase = "idle";
  int    m_env = 0;

  adsr_envelope dut (
    .clk(clk), .rst(rst), .trig(trig), .ai(ai), .di(di), .s(s), .ri(ri),
    .envelope(envelope)
  );

  always #5 clk = ~clk;

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic void model_step();
    int t;
    if (rst) begin
      m_phase = "idle";
      m_env   = 0;
      return;
    end
    case (m_phase)
      "idle":    if (trig) m_phase = "attack";
      "attack":
        if (!trig) m_phase = "release";
        else begin
          t = (sx(ai) <= 0) ? 255 : m_env + sx(ai);
          if (t >= 255) begin m_env = 255; m_phase = "decay"; end
          else m_env = t;
        end
      "decay":
        if (!trig) m_phase = "release";
        else begin
          t = (sx(di) >= 0) ? -1000 : m_env + sx(di);
          if (t <= int'(s)) begin m_env = int'(s); m_phase = "sustain"; end
          else m_env = t;
        end
      "sustain":
        if (!trig) m_phase = "release";
        else m_env = int'(s);
      "release":
        if (trig) m_phase = "attack";
        else begin
          t = (sx(ri) >= 0) ? 0 : m_env + sx(ri);
          if (t <= 0) begin m_env = 0; m_phase = "idle"; end
          else m_env = t;
        end
      default: m_phase = "idle";
    endcase
  endfunction

  // one rising edge; model follows the same sampled inputs; check 1 ns later
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    vectors++;
    assert (envelope === 8'(m_env)) else begin
      errs++;
      $error("FAIL %s: envelope=%0d expected %0d (phase %s)", tag, envelope, m_env, m_phase);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic expect_env(input string tag, input int exp);
    vectors++;
    assert (envelope === 8'(exp)) else begin
      errs++;
      $error("FAIL %s: envelope=%0d expected %0d", tag, envelope, exp);
    end
  endtask

  initial begin
    // 1. reset with trig held
    rst = 1'b1; trig = 1'b1; ai = 8'd5; di = -8'sd10; s = 8'd65; ri = -8'sd1;
    for (int i = 0; i < 5; i++) begin
      tick("reset");
      expect_env("reset_zero", 0);
    end
    rst = 1'b0;
    tick("attack_entry");
    expect_env("attack_entry_zero", 0);

    // 2. full ADSR
    run(1, "attack");
    expect_env("attack_first", 5);
    run(50, "attack");
    expect_env("attack_peak", 255);
    run(1, "decay");
    expect_env("decay_first", 245);
    run(18, "decay");
    expect_env("decay_to_sustain", 65);
    run(300, "sustain");
    expect_env("sustain_hold", 65);
    trig = 1'b0;
    tick("release_hold");
    expect_env("release_hold", 65);
    run(1, "release");
    expect_env("release_first", 64);
    run(64, "release");
    expect_env("release_done", 0);
    run(5, "idle");

    // 3. saturation
    ai = 8'd100; trig = 1'b1;
    tick("sat_entry");
    run(1, "sat"); expect_env("sat_100", 100);
    run(1, "sat"); expect_env("sat_200", 200);
    run(1, "sat"); expect_env("sat_clamp", 255);
    run(19, "sat_decay"); expect_env("sat_decay", 65);
    ri = -8'sd100; trig = 1'b0;
    tick("sat_rel_hold");
    run(1, "sat_rel"); expect_env("release_clamp", 0);
    run(2, "sat_idle");

    // 4. early release
    ai = 8'd5; ri = -8'sd1; trig = 1'b1;
    tick("early_entry");
    run(10, "early_attack"); expect_env("early_50", 50);
    trig = 1'b0;
    run(1, "early_hold"); expect_env("early_hold", 50);
    run(1, "early_rel"); expect_env("early_49", 49);
    run(49, "early_rel"); expect_env("early_zero", 0);

    // 5. retrigger in release
    trig = 1'b1;
    tick("retrig_entry");
    run(6, "retrig_attack"); expect_env("retrig_30", 30);
    trig = 1'b0;
    run(1, "retrig_relhold"); expect_env("retrig_relhold", 30);
    trig = 1'b1;
    run(1, "retrig_hold"); expect_env("retrig_hold", 30);
    run(1, "retrig"); expect_env("retrig_35", 35);
    run(1, "retrig"); expect_env("retrig_40", 40);

    // 6. degenerate increments and live sustain
    ai = 8'd0;
    run(1, "ai_zero"); expect_env("ai_zero", 255);
    di = 8'd0;
    run(1, "di_zero"); expect_env("di_zero", 65);
    s = 8'd100;
    run(1, "s_live"); expect_env("s_live", 100);
    ri = 8'd0; trig = 1'b0;
    run(1, "ri_zero_hold"); expect_env("ri_zero_hold", 100);
    run(1, "ri_zero"); expect_env("ri_zero", 0);

    // reset mid-ramp, then s=255 decay edge case
    ai = 8'd5; trig = 1'b1;
    run(6, "mid_ramp"); expect_env("mid_ramp_25", 25);
    rst = 1'b1;
    run(1, "mid_rst"); expect_env("mid_rst", 0);
    rst = 1'b0; ai = 8'd0; di = -8'sd10; s = 8'd255;
    run(2, "s255"); expect_env("s255_attack", 255);
    run(1, "s255"); expect_env("s255_sustain", 255);
    run(3, "s255_hold");

    // randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) trig = ~trig;
      rst = ($urandom_range(199) == 0);
      if ($urandom_range(7) == 0) ai = 8'($urandom);
      if ($urandom_range(7) == 0) di = 8'($urandom);
      if ($urandom_range(15) == 0) s = 8'($urandom);
      if ($urandom_range(7) == 0) ri = 8'($urandom);
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
